// File: rtl/hk_spi_pkg.sv
// Shared constants, register addresses and FSM state encoding for the housekeeping SPI slave.
package hk_spi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  // Host command bytes
  localparam logic [BYTE_W-1:0] CMD_READ_STREAM  = 8'h40;
  localparam logic [BYTE_W-1:0] CMD_WRITE_STREAM = 8'h80;
  localparam logic [BYTE_W-1:0] CMD_PASSTHRU     = 8'hC4;

  // Register file addresses
  localparam logic [BYTE_W-1:0] REG_ZERO    = 8'h00;
  localparam logic [BYTE_W-1:0] REG_MFG_HI  = 8'h01;
  localparam logic [BYTE_W-1:0] REG_MFG_LO  = 8'h02;
  localparam logic [BYTE_W-1:0] REG_PRODUCT = 8'h03;
  localparam logic [BYTE_W-1:0] REG_SCRATCH = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_PASS
  } hk_state_e;

endpackage

// File: rtl/hk_sync2.sv
// Two-flop synchroniser for an asynchronous pad input, with edge pulses on the synchronised copy.
module hk_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise_c = q & ~prev;
  assign fall_c = ~q & prev;

endmodule

// File: rtl/hk_spi_passthru.sv
// Housekeeping SPI slave: small ID/scratch register file plus a flash pass-thru mode
// that hands the host pins to the management flash while holding the CPU in reset.
module hk_spi_passthru
  import hk_spi_pkg::*;
#(
  parameter logic [7:0]  PRODUCT_ID = 8'h10,
  parameter logic [11:0] MFG_ID     = 12'h456
) (
  input  logic clock,
  input  logic reset,
  input  logic sck,
  input  logic csb,
  input  logic sdi,
  output logic sdo,
  output logic sdo_enb,
  input  logic cpu_flash_csb,
  input  logic cpu_flash_clk,
  input  logic cpu_flash_io0,
  output logic flash_csb,
  output logic flash_clk,
  output logic flash_io0,
  input  logic flash_io1,
  output logic mgmt_reset,
  output logic pass_thru
);

  logic sck_rise_c, csb_q, csb_fall_c, sdi_q;
  logic unused_sck_q, unused_sck_fall, unused_csb_rise, unused_sdi_rise, unused_sdi_fall;

  hk_sync2 u_sync_sck (.clock(clock), .reset(reset), .d(sck), .q(unused_sck_q),
                       .rise_c(sck_rise_c), .fall_c(unused_sck_fall));
  hk_sync2 u_sync_csb (.clock(clock), .reset(reset), .d(csb), .q(csb_q),
                       .rise_c(unused_csb_rise), .fall_c(csb_fall_c));
  hk_sync2 u_sync_sdi (.clock(clock), .reset(reset), .d(sdi), .q(sdi_q),
                       .rise_c(unused_sdi_rise), .fall_c(unused_sdi_fall));

  hk_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [BYTE_W-1:0] shreg_q, addr_q, scratch_q;
  logic              rd_mode_q;

  logic              shift_en_c, byte_done_c;
  logic [BYTE_W-1:0] byte_in_c, rd_addr_c, rd_data_c;

  // Register file read mux
  function automatic logic [BYTE_W-1:0] reg_rd(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] scr);
    case (a)
      REG_ZERO:    reg_rd = 8'h00;
      REG_MFG_HI:  reg_rd = {4'h0, MFG_ID[11:8]};
      REG_MFG_LO:  reg_rd = MFG_ID[7:0];
      REG_PRODUCT: reg_rd = PRODUCT_ID;
      REG_SCRATCH: reg_rd = scr;
      default:     reg_rd = 8'h00;
    endcase
  endfunction

  assign shift_en_c  = sck_rise_c && !csb_q &&
                       ((state_q == ST_CMD) || (state_q == ST_ADDR) ||
                        (state_q == ST_DATA_RD) || (state_q == ST_DATA_WR));
  assign byte_done_c = shift_en_c && (bit_cnt_q == CNT_W'(7));
  assign byte_in_c   = {shreg_q[BYTE_W-2:0], sdi_q};
  // Next read address: the address byte itself, or the auto-incremented stream address
  assign rd_addr_c   = (state_q == ST_ADDR) ? byte_in_c : addr_q + 8'd1;
  assign rd_data_c   = reg_rd(rd_addr_c, scratch_q);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a deasserted chip select always wins
  always_comb begin
    state_d = state_q;
    if (csb_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (csb_fall_c) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done_c) begin
            case (byte_in_c)
              CMD_READ_STREAM, CMD_WRITE_STREAM: state_d = ST_ADDR;
              CMD_PASSTHRU:                      state_d = ST_PASS;
              default:                           state_d = ST_IDLE;
            endcase
          end
        end
        ST_ADDR: if (byte_done_c) state_d = rd_mode_q ? ST_DATA_RD : ST_DATA_WR;
        default: state_d = state_q;
      endcase
    end
  end

  // Shift/count datapath, register writes and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      addr_q     <= '0;
      scratch_q  <= '0;
      rd_mode_q  <= 1'b0;
      pass_thru  <= 1'b0;
      mgmt_reset <= 1'b0;
      sdo_enb    <= 1'b1;
    end else begin
      pass_thru  <= (state_d == ST_PASS);
      mgmt_reset <= (state_d == ST_PASS);
      sdo_enb    <= !((state_d == ST_DATA_RD) || (state_d == ST_PASS));
      if (csb_q) begin
        bit_cnt_q <= '0;
      end else if (shift_en_c) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        shreg_q   <= (state_q == ST_DATA_RD) ? {shreg_q[BYTE_W-2:0], 1'b0} : byte_in_c;
        if (byte_done_c) begin
          case (state_q)
            ST_CMD:  rd_mode_q <= (byte_in_c == CMD_READ_STREAM);
            ST_ADDR: begin
              addr_q  <= byte_in_c;
              shreg_q <= rd_data_c;
            end
            ST_DATA_RD: begin
              addr_q  <= addr_q + 8'd1;
              shreg_q <= rd_data_c;
            end
            ST_DATA_WR: begin
              if (addr_q == REG_SCRATCH) scratch_q <= byte_in_c;
              addr_q <= addr_q + 8'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Pad muxing: raw host pins go straight to the flash while pass-thru is active
  assign sdo       = pass_thru ? flash_io1 : (sdo_enb ? 1'b0 : shreg_q[BYTE_W-1]);
  assign flash_csb = pass_thru ? csb : cpu_flash_csb;
  assign flash_clk = pass_thru ? sck : cpu_flash_clk;
  assign flash_io0 = pass_thru ? sdi : cpu_flash_io0;

endmodule

// File: tb/tb_hk_spi_passthru.sv
// Self-checking bench for hk_spi_passthru: SPI host driver, SPI flash model and register-map model.
module tb_hk_spi_passthru;

  localparam int HP = 6;  // SPI half period in system clocks

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0, csb = 1'b1, sdi = 1'b0;
  logic sdo, sdo_enb;
  logic cpu_flash_csb = 1'b1, cpu_flash_clk = 1'b0, cpu_flash_io0 = 1'b0;
  logic flash_csb, flash_clk, flash_io0;
  logic flash_io1 = 1'b0;
  logic mgmt_reset, pass_thru;

  int total = 0;
  int bad = 0;

  hk_spi_passthru dut (
    .clock(clock), .reset(reset), .sck(sck), .csb(csb), .sdi(sdi),
    .sdo(sdo), .sdo_enb(sdo_enb),
    .cpu_flash_csb(cpu_flash_csb), .cpu_flash_clk(cpu_flash_clk), .cpu_flash_io0(cpu_flash_io0),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0), .flash_io1(flash_io1),
    .mgmt_reset(mgmt_reset), .pass_thru(pass_thru)
  );

  always #5 clock = ~clock;

  // Flash model: 0x03 read with 24-bit address, data shifted out on the falling clock
  logic [7:0]  f_mem [8] = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
  int          f_bits = 0;
  int          f_k;
  logic [31:0] f_cmd = '0;

  always @(posedge flash_clk or posedge flash_csb) begin
    if (flash_csb) f_bits = 0;
    else begin
      if (f_bits < 32) f_cmd = {f_cmd[30:0], flash_io0};
      f_bits++;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && f_bits >= 32 && f_cmd[31:24] == 8'h03) begin
      f_k = f_bits - 32;
      flash_io1 = f_mem[(int'(f_cmd[23:0]) + f_k / 8) % 8][7 - (f_k % 8)];
    end
  end

  // Register-map reference model
  logic [7:0] model_mem [256];
  bit         model_wr  [256];

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'h00;
      model_wr[i]  = 1'b0;
    end
    model_mem[1] = 8'h04;
    model_mem[2] = 8'h56;
    model_mem[3] = 8'h10;
    model_wr[4]  = 1'b1;
  endtask

  logic [7:0] rd_q [$];
  logic [7:0] wr_q [$];
  int hdr_low, data_low;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output int enb_low);
    rx = '0;
    enb_low = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      sdi = tx[i];
      wait_clks(HP);
      rx[i] = sdo;
      if (sdo_enb === 1'b0) enb_low++;
      sck = 1'b1;
      wait_clks(HP);
      sck = 1'b0;
    end
  endtask

  task automatic start_txn();
    csb = 1'b0;
    wait_clks(HP);
  endtask

  task automatic end_txn();
    sck = 1'b0;
    wait_clks(HP);
    csb = 1'b1;
    wait_clks(HP);
  endtask

  task automatic do_read(input logic [7:0] a, input int n);
    logic [7:0] rx;
    int e;
    rd_q.delete();
    hdr_low = 0;
    data_low = 0;
    start_txn();
    spi_bits(8'h40, 8, rx, e); hdr_low += e;
    spi_bits(a, 8, rx, e);     hdr_low += e;
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8, rx, e);
      data_low += e;
      rd_q.push_back(rx);
    end
    end_txn();
  endtask

  task automatic do_write(input logic [7:0] a);
    logic [7:0] rx;
    int e;
    hdr_low = 0;
    start_txn();
    spi_bits(8'h80, 8, rx, e); hdr_low += e;
    spi_bits(a, 8, rx, e);     hdr_low += e;
    foreach (wr_q[k]) begin
      spi_bits(wr_q[k], 8, rx, e);
      hdr_low += e;
    end
    end_txn();
    foreach (wr_q[k]) if (model_wr[8'(a + k)]) model_mem[8'(a + k)] = wr_q[k];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_flash_csb = 1'b1; cpu_flash_clk = 1'b0; cpu_flash_io0 = 1'b1;
    wait_clks(3);
    total++; if (sdo !== 1'b0)        begin bad++; $display("FAIL reset_sdo got=%b want=0", sdo); end
    total++; if (sdo_enb !== 1'b1)    begin bad++; $display("FAIL reset_sdo_enb got=%b want=1", sdo_enb); end
    total++; if (pass_thru !== 1'b0)  begin bad++; $display("FAIL reset_pass_thru got=%b want=0", pass_thru); end
    total++; if (mgmt_reset !== 1'b0) begin bad++; $display("FAIL reset_mgmt_reset got=%b want=0", mgmt_reset); end
    total++; if ({flash_csb, flash_clk, flash_io0} !== 3'b101)
      begin bad++; $display("FAIL reset_flash_pins got=%b want=101", {flash_csb, flash_clk, flash_io0}); end
    cpu_flash_io0 = 1'b0;
    reset = 1'b0;
    model_reset();
    wait_clks(HP);
  endtask

  task automatic test_read_product();
    do_read(8'h03, 1);
    total++; if (rd_q[0] !== model_mem[3]) begin bad++; $display("FAIL read_product got=%h want=%h", rd_q[0], model_mem[3]); end
    total++; if (hdr_low !== 0)  begin bad++; $display("FAIL read_hdr_enb low_samples=%0d want=0", hdr_low); end
    total++; if (data_low !== 8) begin bad++; $display("FAIL read_data_enb low_samples=%0d want=8", data_low); end
    total++; if (sdo_enb !== 1'b1) begin bad++; $display("FAIL read_idle_enb got=%b want=1", sdo_enb); end
  endtask

  task automatic test_stream_read();
    logic [7:0] a;
    int n;
    do_read(8'h01, 3);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rd_q[k] !== model_mem[1 + k]) begin bad++; $display("FAIL stream_read[%0d] got=%h want=%h", k, rd_q[k], model_mem[1 + k]); end
    end
    for (int it = 0; it < 5; it++) begin
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(8'hFD, 8'hFF));
      n = $urandom_range(2, 4);
      do_read(a, n);
      for (int k = 0; k < n; k++) begin
        total++;
        if (rd_q[k] !== model_mem[8'(a + k)])
          begin bad++; $display("FAIL stream_rand addr=%h idx=%0d got=%h want=%h", a, k, rd_q[k], model_mem[8'(a + k)]); end
      end
      total++; if (data_low !== 8 * n) begin bad++; $display("FAIL stream_enb low_samples=%0d want=%0d", data_low, 8 * n); end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] a, rx;
    int n, e;
    wr_q = '{8'hA5};
    do_write(8'h04);
    do_read(8'h04, 1);
    total++; if (rd_q[0] !== 8'hA5) begin bad++; $display("FAIL write_scratch got=%h want=a5", rd_q[0]); end
    wr_q = '{8'($urandom_range(0, 255))};
    do_write(8'h03);
    do_read(8'h03, 1);
    total++; if (rd_q[0] !== 8'h10) begin bad++; $display("FAIL write_readonly got=%h want=10", rd_q[0]); end
    total++; if (hdr_low !== 0) begin bad++; $display("FAIL write_enb low_samples=%0d want=0", hdr_low); end
    for (int it = 0; it < 3; it++) begin
      a = 8'($urandom_range(0, 5));
      n = $urandom_range(1, 3);
      wr_q.delete();
      for (int k = 0; k < n; k++) wr_q.push_back(8'($urandom_range(1, 255)));
      do_write(a);
      do_read(8'h00, 6);
      for (int k = 0; k < 6; k++) begin
        total++;
        if (rd_q[k] !== model_mem[k]) begin bad++; $display("FAIL write_rand reg=%0d got=%h want=%h", k, rd_q[k], model_mem[k]); end
      end
    end
    // Partial write byte aborted by csb must not land
    start_txn();
    spi_bits(8'h80, 8, rx, e);
    spi_bits(8'h04, 8, rx, e);
    spi_bits(~model_mem[4], 5, rx, e);
    end_txn();
    do_read(8'h04, 1);
    total++; if (rd_q[0] !== model_mem[4]) begin bad++; $display("FAIL partial_write got=%h want=%h", rd_q[0], model_mem[4]); end
  endtask

  task automatic test_passthru();
    logic [7:0] rx;
    int e, k;
    logic [2:0] cpu;
    cpu_flash_clk = 1'b1;
    start_txn();
    spi_bits(8'hC4, 8, rx, e);
    total++; if ({pass_thru, mgmt_reset} !== 2'b11) begin bad++; $display("FAIL pass_enter got=%b want=11", {pass_thru, mgmt_reset}); end
    spi_bits(8'h03, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    spi_bits(8'h00, 8, rx, e);
    sdi = ~sdi;
    #1;
    total++; if (flash_io0 !== sdi) begin bad++; $display("FAIL pass_io0_comb got=%b want=%b", flash_io0, sdi); end
    for (int b = 0; b < 8; b++) begin
      spi_bits(8'h00, 8, rx, e);
      total++; if (rx !== f_mem[b]) begin bad++; $display("FAIL pass_flash_byte[%0d] got=%h want=%h", b, rx, f_mem[b]); end
      total++; if (e !== 8) begin bad++; $display("FAIL pass_enb[%0d] low_samples=%0d want=8", b, e); end
    end
    total++; if (mgmt_reset !== 1'b1) begin bad++; $display("FAIL pass_mgmt_hold got=%b want=1", mgmt_reset); end
    sck = 1'b0;
    wait_clks(HP);
    csb = 1'b1;
    k = 0;
    while (mgmt_reset !== 1'b0 && k < 4) begin
      wait_clks(1);
      k++;
    end
    total++; if ({pass_thru, mgmt_reset} !== 2'b00) begin bad++; $display("FAIL pass_exit got=%b want=00 after %0d clks", {pass_thru, mgmt_reset}, k); end
    for (int it = 0; it < 4; it++) begin
      cpu = 3'($urandom_range(0, 7));
      {cpu_flash_csb, cpu_flash_clk, cpu_flash_io0} = cpu;
      #1;
      total++; if ({flash_csb, flash_clk, flash_io0} !== cpu)
        begin bad++; $display("FAIL pass_cpu_pins got=%b want=%b", {flash_csb, flash_clk, flash_io0}, cpu); end
      wait_clks(1);
    end
    cpu_flash_csb = 1'b1; cpu_flash_clk = 1'b0; cpu_flash_io0 = 1'b0;
    wait_clks(HP);
  endtask

  task automatic test_post_pass();
    logic [7:0] rx;
    int e, lows;
    do_read(8'h03, 1);
    total++; if (rd_q[0] !== 8'h10) begin bad++; $display("FAIL post_pass_product got=%h want=10", rd_q[0]); end
    lows = 0;
    start_txn();
    spi_bits(8'h13, 8, rx, e); lows += e;
    spi_bits(8'h04, 8, rx, e); lows += e;
    spi_bits(8'($urandom_range(0, 255)), 8, rx, e); lows += e;
    end_txn();
    total++; if (lows !== 0) begin bad++; $display("FAIL illegal_cmd_enb low_samples=%0d want=0", lows); end
    do_read(8'h00, 5);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rd_q[k] !== model_mem[k]) begin bad++; $display("FAIL illegal_cmd_regs reg=%0d got=%h want=%h", k, rd_q[k], model_mem[k]); end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] rx;
    int e;
    wr_q = '{8'h5A};
    do_write(8'h04);
    start_txn();
    spi_bits(8'hC4, 8, rx, e);
    total++; if (pass_thru !== 1'b1) begin bad++; $display("FAIL abort_pass_enter got=%b want=1", pass_thru); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    total++; if ({pass_thru, mgmt_reset} !== 2'b00) begin bad++; $display("FAIL abort_status got=%b want=00", {pass_thru, mgmt_reset}); end
    total++; if ({flash_csb, flash_clk, flash_io0} !== {cpu_flash_csb, cpu_flash_clk, cpu_flash_io0})
      begin bad++; $display("FAIL abort_flash_pins got=%b want=%b", {flash_csb, flash_clk, flash_io0}, {cpu_flash_csb, cpu_flash_clk, cpu_flash_io0}); end
    wait_clks(2);
    reset = 1'b0;
    csb = 1'b1;
    wait_clks(HP);
    model_mem[4] = 8'h00;
    do_read(8'h04, 1);
    total++; if (rd_q[0] !== 8'h00) begin bad++; $display("FAIL abort_scratch_cleared got=%h want=00", rd_q[0]); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_product();
    test_stream_read();
    test_write_read();
    test_passthru();
    test_post_pass();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
